euclid_array_ctrl: RTL
======================

// Module: euclid_array_ctrl
// PURPOSE
//  Sequencer for the systolic Euclidean key-equation array of the BCH decoder, GF(2^13).
//  Accepts 2T syndromes and streams the initial polynomials into cell 0, coefficient-serial:
//  R=x^2T, Q=S(x), L=0, U=1.
//  Waits for the start token to leave the last cell. Captures the error-locator coefficients
//  from the last cell's L output and returns them to the Chien stage over valid/ready.
// PARAMETERS
//  T        8   correctable errors; array carries N=2T+1 coefficients per polynomial
//  NCELL    16  cells in the array (2T)
//  CELL_LAT 3   start-token latency per cell, in clk cycles
//  ST_OFS   0   cycles from arr_st_in rise to the first captured L coefficient (0..3)
//  TMO      NCELL*CELL_LAT+8   WAIT-state timeout, in cycles
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low
//  syn_valid    in   1   syndrome word valid
//  syn_ready    out  1   ctrl accepts syndrome (high only in LOAD)
//  syn_data     in   13  syndrome S_i, sent in order S_1..S_2T
//  arr_start    out  1   one-cycle start token to cell 0
//  arr_R/Q/L/U  out  13  coefficient streams to cell 0 (four ports)
//  arr_deg_R    out  5   initial deg R, held at 2T
//  arr_deg_Q    out  5   initial deg Q, held at 2T-1
//  arr_stop     out  1   stop flag to cell 0, held 0
//  arr_st_in    in   1   start token from last cell
//  arr_L_in     in   13  L coefficient stream from last cell
//  arr_deg_in   in   5   deg_R output of last cell (sampled as locator degree)
//  loc_valid    out  1   locator coefficient valid
//  loc_ready    in   1   downstream accepts coefficient
//  loc_data     out  13  lambda_k, ascending k = 0..T
//  loc_last     out  1   high with lambda_T
//  loc_deg      out  5   captured locator degree, stable while loc_valid
//  busy         out  1   high in every state except LOAD
//  err_tmo      out  1   one-cycle pulse on WAIT timeout
// BEHAVIOUR
//  Reset (async, reset=0):
//  - State = LOAD; all counters and buffers = 0.
//  - All outputs = 0, except syn_ready = 1 once reset is released.
//  FSM: LOAD -> FEED -> WAIT -> COLLECT -> OUT -> LOAD.
//  LOAD
//  - Each cycle with syn_valid&syn_ready writes syn_data to sbuf[i], i = 0..2T-1.
//  - The 2T-th write moves to FEED on the next cycle. Gaps in syn_valid are allowed.
//  - syn_valid outside LOAD is ignored (syn_ready=0).
//  FEED: exactly N cycles, k = 0..2T; stream index k carries degree 2T-k.
//  - arr_start = 1 at k=0 only.
//  - arr_R = 1 at k=0, else 0.
//  - arr_Q = 0 at k=0; sbuf[2T-k] for k >= 1 (S_2T first, S_1 last).
//  - arr_L = 0 always.
//  - arr_U = 1 at k=2T, else 0.
//  - In all other states, arr_R/Q/L/U/start = 0.
//  WAIT
//  - Timeout counter clears on entry.
//  - First cycle with arr_st_in=1 arms COLLECT, starting ST_OFS cycles later.
//  - Counter reaching TMO: err_tmo pulses, state -> LOAD, no locator output.
//  - arr_st_in in any other state is ignored.
//  COLLECT: N cycles; capture cycle c carries degree 2T-c.
//  - For c >= 2T-T, lbuf[2T-c] <= arr_L_in.
//  - arr_deg_in is sampled into loc_deg at c = 0.
//  - Then go to OUT.
//  OUT
//  - loc_data = lbuf[j], j = 0..T; loc_valid = 1.
//  - j advances only on loc_valid&loc_ready.
//  - While loc_ready=0, data/last are held stable.
//  - The handshake with loc_last=1 returns to LOAD next cycle.
//  - loc_last=0 on every other beat.
//  - Latency: last syndrome accepted to first loc_valid = N + (wait) + ST_OFS + N + 1 cycles.
//  Widths
//  - Counters are sized for max(N, TMO).
//  - No GF arithmetic here; all arithmetic is in the cells.
//  Reset mid-operation: immediate return to the reset state, with any partial output discarded.
// TESTING (bench: NCELL euclidean cells chained + this block)
//  1. All-zero syndromes -> loc_deg=0; lambda_0 != 0, lambda_1..T = 0; 9 beats, loc_last on beat 9.
//  2. Single error at alpha^5 (S_i=alpha^(5i)) -> loc_deg=1; lambda_1/lambda_0 = alpha^5 (GF model check).
//  3. T=8 errors, random positions -> locator roots match injected positions (1000 seeds, golden C model).
//  4. loc_ready low 10 cycles after beat 3 -> loc_data/loc_last held; no beat lost or repeated.
//  5. arr_st_in forced 0 -> err_tmo pulses exactly TMO cycles after WAIT entry; syn_ready=1 next cycle.
//  6. reset pulsed low at FEED k=7 -> all outputs 0 immediately; new block after release decodes correctly.

Source files
------------

// File: rtl/euclid_array_ctrl.sv
// Sequencer for the systolic Euclidean key-equation array: loads 2T syndromes, seeds cell 0,
// waits for the start token to leave the last cell, captures the locator and streams it out.
module euclid_array_ctrl #(
  parameter int T        = 8,
  parameter int NCELL    = 16,
  parameter int CELL_LAT = 3,
  parameter int ST_OFS   = 0,
  parameter int TMO      = NCELL * CELL_LAT + 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syn_valid,
  output logic        syn_ready,
  input  logic [12:0] syn_data,
  output logic        arr_start,
  output logic [12:0] arr_R,
  output logic [12:0] arr_Q,
  output logic [12:0] arr_L,
  output logic [12:0] arr_U,
  output logic [4:0]  arr_deg_R,
  output logic [4:0]  arr_deg_Q,
  output logic        arr_stop,
  input  logic        arr_st_in,
  input  logic [12:0] arr_L_in,
  input  logic [4:0]  arr_deg_in,
  output logic        loc_valid,
  input  logic        loc_ready,
  output logic [12:0] loc_data,
  output logic        loc_last,
  output logic [4:0]  loc_deg,
  output logic        busy,
  output logic        err_tmo
);

  localparam int N    = 2 * T + 1;
  localparam int CMAX = (TMO > ST_OFS + N) ? TMO : ST_OFS + N;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = $clog2(2 * T);
  localparam int LW   = $clog2(T + 1);

  localparam logic [CW-1:0] C_ZERO   = CW'(0);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_T      = CW'(T);
  localparam logic [CW-1:0] C_2T     = CW'(2 * T);
  localparam logic [CW-1:0] C_2T_M1  = CW'(2 * T - 1);
  localparam logic [CW-1:0] C_TMO    = CW'(TMO);
  localparam logic [CW-1:0] C_TMO_M1 = CW'(TMO - 1);
  localparam logic [CW-1:0] C_OFS    = CW'(ST_OFS);
  localparam logic [4:0]    DEG_R    = 5'(2 * T);
  localparam logic [4:0]    DEG_Q    = 5'(2 * T - 1);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_FEED    = 3'd1,
    S_WAIT    = 3'd2,
    S_COLLECT = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [12:0]   sbuf_q [2*T];
  logic [12:0]   sbuf_d [2*T];
  logic [12:0]   lbuf_q [T+1];
  logic [12:0]   lbuf_d [T+1];
  logic [4:0]    loc_deg_q, loc_deg_d;
  logic          err_tmo_q, err_tmo_d;
  logic [CW:0]   coll_ext_s;
  logic [CW-1:0] coll_c_s;
  logic [LW-1:0] lidx_s;
  logic [SW-1:0] qidx_s;

  logic          syn_ready_q, syn_ready_d;
  logic          busy_q, busy_d;
  logic          arr_start_q, arr_start_d;
  logic [12:0]   arr_r_q, arr_r_d;
  logic [12:0]   arr_q_q, arr_q_d;
  logic [12:0]   arr_u_q, arr_u_d;
  logic [4:0]    arr_deg_r_q, arr_deg_q_q;
  logic          loc_valid_q, loc_valid_d;
  logic [12:0]   loc_data_q, loc_data_d;
  logic          loc_last_q, loc_last_d;

  // Next-state, counter and buffer update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sbuf_d    = sbuf_q;
    lbuf_d    = lbuf_q;
    loc_deg_d = loc_deg_q;
    err_tmo_d = 1'b0;
    // Capture index lags the COLLECT counter by ST_OFS; the extra top bit flags "not yet".
    coll_ext_s = {1'b0, cnt_q} - {1'b0, C_OFS};
    coll_c_s   = coll_ext_s[CW-1:0];
    lidx_s     = LW'(2 * T) - coll_c_s[LW-1:0];
    case (state_q)
      S_LOAD: begin
        if (syn_valid && syn_ready_q) begin
          sbuf_d[cnt_q[SW-1:0]] = syn_data;
          if (cnt_q == C_2T_M1) begin
            state_d = S_FEED;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_FEED: begin
        if (cnt_q == C_2T) begin
          state_d = S_WAIT;
          cnt_d   = C_ZERO;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == C_TMO) begin
          state_d = S_LOAD;
          cnt_d   = C_ZERO;
        end else if (arr_st_in) begin
          state_d = S_COLLECT;
          cnt_d   = C_ZERO;
        end else begin
          cnt_d     = cnt_q + C_ONE;
          err_tmo_d = (cnt_q == C_TMO_M1);
        end
      end
      S_COLLECT: begin
        if (!coll_ext_s[CW]) begin
          if (coll_c_s == C_ZERO) begin
            loc_deg_d = arr_deg_in;
          end else begin
            loc_deg_d = loc_deg_q;
          end
          if (coll_c_s >= C_T) begin
            lbuf_d[lidx_s] = arr_L_in;
          end else begin
            lbuf_d = lbuf_q;
          end
          if (coll_c_s == C_2T) begin
            state_d = S_OUT;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_OUT: begin
        if (loc_valid_q && loc_ready) begin
          if (cnt_q == C_T) begin
            state_d = S_LOAD;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = C_ZERO;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so every output is a flop.
  always_comb begin
    syn_ready_d = (state_d == S_LOAD);
    busy_d      = (state_d != S_LOAD);
    arr_start_d = 1'b0;
    arr_r_d     = 13'd0;
    arr_q_d     = 13'd0;
    arr_u_d     = 13'd0;
    loc_valid_d = 1'b0;
    loc_data_d  = 13'd0;
    loc_last_d  = 1'b0;
    // Stream index k carries degree 2T-k, so Q walks the syndromes from S_2T down to S_1.
    qidx_s      = SW'(2 * T) - cnt_d[SW-1:0];
    if (state_d == S_FEED) begin
      arr_start_d = (cnt_d == C_ZERO);
      arr_r_d     = {12'd0, (cnt_d == C_ZERO)};
      arr_u_d     = {12'd0, (cnt_d == C_2T)};
      if (cnt_d != C_ZERO) begin
        arr_q_d = sbuf_q[qidx_s];
      end else begin
        arr_q_d = 13'd0;
      end
    end else begin
      arr_start_d = 1'b0;
    end
    if (state_d == S_OUT) begin
      loc_valid_d = 1'b1;
      loc_data_d  = lbuf_d[cnt_d[LW-1:0]];
      loc_last_d  = (cnt_d == C_T);
    end else begin
      loc_valid_d = 1'b0;
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      cnt_q       <= C_ZERO;
      for (int i = 0; i < 2 * T; i++) sbuf_q[i] <= 13'd0;
      for (int i = 0; i <= T; i++) lbuf_q[i] <= 13'd0;
      loc_deg_q   <= 5'd0;
      err_tmo_q   <= 1'b0;
      syn_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      arr_start_q <= 1'b0;
      arr_r_q     <= 13'd0;
      arr_q_q     <= 13'd0;
      arr_u_q     <= 13'd0;
      arr_deg_r_q <= 5'd0;
      arr_deg_q_q <= 5'd0;
      loc_valid_q <= 1'b0;
      loc_data_q  <= 13'd0;
      loc_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sbuf_q      <= sbuf_d;
      lbuf_q      <= lbuf_d;
      loc_deg_q   <= loc_deg_d;
      err_tmo_q   <= err_tmo_d;
      syn_ready_q <= syn_ready_d;
      busy_q      <= busy_d;
      arr_start_q <= arr_start_d;
      arr_r_q     <= arr_r_d;
      arr_q_q     <= arr_q_d;
      arr_u_q     <= arr_u_d;
      arr_deg_r_q <= DEG_R;
      arr_deg_q_q <= DEG_Q;
      loc_valid_q <= loc_valid_d;
      loc_data_q  <= loc_data_d;
      loc_last_q  <= loc_last_d;
    end
  end

  assign syn_ready = syn_ready_q;
  assign busy      = busy_q;
  assign arr_start = arr_start_q;
  assign arr_R     = arr_r_q;
  assign arr_Q     = arr_q_q;
  assign arr_L     = 13'd0;
  assign arr_U     = arr_u_q;
  assign arr_deg_R = arr_deg_r_q;
  assign arr_deg_Q = arr_deg_q_q;
  assign arr_stop  = 1'b0;
  assign loc_valid = loc_valid_q;
  assign loc_data  = loc_data_q;
  assign loc_last  = loc_last_q;
  assign loc_deg   = loc_deg_q;
  assign err_tmo   = err_tmo_q;

endmodule
